// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults for the FIFO pointer controller and its storage.
// This package holds the default sizes, the default almost-full/almost-empty levels and a level sanity check.
package fifo_ctrl_pkg;

    localparam int FIFO_W        = 5;   // address width; depth = 2**FIFO_W
    localparam int FIFO_B        = 8;   // data width of the paired reg_file
    localparam int FIFO_AF_LEVEL = 28;
    localparam int FIFO_AE_LEVEL = 4;

    // Levels must satisfy 0 < ae < af < 2**w.
    function automatic bit levels_legal(input int w, input int af, input int ae);
        return (ae > 0) && (ae < af) && (af < (1 << w));
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/flag bundle between a FIFO user (master) and fifo_ctrl (slave).
// Handshake: a push is taken on an edge where wr & ~full, a pop where rd & ~empty; there is no other qualifier.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int W = FIFO_W
) ();

    logic         wr;
    logic         rd;
    logic         clr_err;
    logic         wr_en;
    logic [W-1:0] w_addr;
    logic [W-1:0] r_addr;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;

    modport master (
        output wr, rd, clr_err,
        input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, rd, clr_err,
        output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a 2**W-deep synchronous FIFO built on reg_file.
// Read port A of reg_file is addressed by r_addr, so the head is visible before the pop edge.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int W        = FIFO_W,
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic       clk,
    input  logic       n_reset,
    fifo_ctrl_if.slave bus
);

    localparam logic [W:0] AF_CNT = (W+1)'(AF_LEVEL);
    localparam logic [W:0] AE_CNT = (W+1)'(AE_LEVEL);

    if (!levels_legal(W, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("fifo_ctrl: AE_LEVEL/AF_LEVEL outside 0 < AE < AF < 2**W");
    end

    // One extra MSB on each pointer distinguishes full from empty when the low bits match.
    logic [W:0] wr_ptr_q, wr_ptr_d;
    logic [W:0] rd_ptr_q, rd_ptr_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;

    logic [W:0] count_w;
    logic       full_w;
    logic       empty_w;
    logic       push_ok;
    logic       pop_ok;

    assign count_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (wr_ptr_q[W] != rd_ptr_q[W]) &&
                     (wr_ptr_q[W-1:0] == rd_ptr_q[W-1:0]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign push_ok = bus.wr & ~full_w;
    assign pop_ok  = bus.rd & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Clear is applied first so a same-cycle set overrides it.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.wr && full_w)  overflow_d  = 1'b1;
        if (bus.rd && empty_w) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.wr_en        = push_ok;
    assign bus.w_addr       = wr_ptr_q[W-1:0];
    assign bus.r_addr       = rd_ptr_q[W-1:0];
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_w >= AF_CNT);
    assign bus.almost_empty = (count_w <= AE_CNT);
    assign bus.count        = count_w;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small array standing in for reg_file.
// Pushed data is queued as the expected head; a negedge monitor compares every accepted pop.
module tb_fifo_ctrl;

    localparam int W     = 5;
    localparam int DEPTH = 1 << W;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [7:0] w_data;
    logic [7:0] mem [DEPTH];
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    int         total = 0;
    int         bad   = 0;
    int         m_count;
    logic [W-1:0] m_wp;
    logic [W-1:0] m_rp;
    logic [W-1:0] prev_waddr;
    bit         saw_wrap;

    fifo_ctrl_if #(.W(W)) bus ();

    fifo_ctrl #(.W(W), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for reg_file: write on wr_en, port A is combinational head read.
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.w_addr] <= w_data;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected value.
    always @(negedge clk) begin
        if (n_reset && bus.rd && !bus.empty) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL head: popped %0d, nothing expected", mem[bus.r_addr]);
            end else begin
                exp_v = exp_q.pop_front();
                if (mem[bus.r_addr] !== exp_v) begin
                    bad++;
                    $display("FAIL head: got %0d, want %0d", mem[bus.r_addr], exp_v);
                end
            end
        end
    end

    task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
        bit push_ok;
        bit pop_ok;
        bus.wr      = w;
        bus.rd      = r;
        bus.clr_err = c;
        w_data      = d;
        push_ok     = w && (m_count < DEPTH);
        pop_ok      = r && (m_count > 0);
        #1;
        chk("wr_en", int'(bus.wr_en), int'(push_ok));
        if (push_ok) exp_q.push_back(d);
        @(posedge clk);
        m_count = m_count + int'(push_ok) - int'(pop_ok);
        if (push_ok) m_wp++;
        if (pop_ok)  m_rp++;
        #1;
        chk("count",  int'(bus.count),  m_count);
        chk("w_addr", int'(bus.w_addr), int'(m_wp));
        chk("r_addr", int'(bus.r_addr), int'(m_rp));
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wp    = '0;
        m_rp    = '0;
        exp_q.delete();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        w_data      = '0;
        model_reset();

        // Reset then idle.
        n_reset = 1'b0;
        #20;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_empty",  int'(bus.empty), 1);
        chk("rst_full",   int'(bus.full), 0);
        chk("rst_count",  int'(bus.count), 0);
        chk("rst_ae",     int'(bus.almost_empty), 1);
        chk("rst_af",     int'(bus.almost_full), 0);
        chk("rst_raddr",  int'(bus.r_addr), 0);
        chk("rst_waddr",  int'(bus.w_addr), 0);
        chk("rst_wr_en",  int'(bus.wr_en), 0);
        chk("rst_ovf",    int'(bus.overflow), 0);
        chk("rst_unf",    int'(bus.underflow), 0);

        // Pop on empty, then clear together with another bad pop: set wins.
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("unf_set", int'(bus.underflow), 1);
        step(1'b0, 1'b1, 1'b1, 8'd0);
        chk("unf_set_wins", int'(bus.underflow), 1);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        chk("unf_clr", int'(bus.underflow), 0);

        // Three pushes then three pops; monitor checks 10, 15, 20 in order.
        step(1'b1, 1'b0, 1'b0, 8'd10);
        step(1'b1, 1'b0, 1'b0, 8'd15);
        step(1'b1, 1'b0, 1'b0, 8'd20);
        chk("cnt3", int'(bus.count), 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("drain3_empty", int'(bus.empty), 1);

        // Fill to full with data = index.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 26) chk("af_at27", int'(bus.almost_full), 0);
            if (i == 27) chk("af_at28", int'(bus.almost_full), 1);
            if (i == 30) chk("full_at31", int'(bus.full), 0);
            if (i == 31) chk("full_at32", int'(bus.full), 1);
        end
        step(1'b1, 1'b0, 1'b0, 8'hEE);
        chk("ovf_set", int'(bus.overflow), 1);
        chk("ovf_cnt", int'(bus.count), 32);

        // wr & rd while full: pop only, no pass-through.
        step(1'b1, 1'b1, 1'b0, 8'hDD);
        chk("wrrd_full_cnt",  int'(bus.count), 31);
        chk("wrrd_full_full", int'(bus.full), 0);
        chk("wrrd_full_ovf",  int'(bus.overflow), 1);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        chk("ovf_clr", int'(bus.overflow), 0);

        for (int i = 0; i < 31; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            if (i == 25) chk("ae_at5", int'(bus.almost_empty), 0);
            if (i == 26) chk("ae_at4", int'(bus.almost_empty), 1);
        end
        chk("drain_empty", int'(bus.empty), 1);

        // wr & rd while empty: push only, no bypass.
        step(1'b1, 1'b1, 1'b0, 8'd55);
        chk("wrrd_empty_cnt", int'(bus.count), 1);
        chk("wrrd_empty_unf", int'(bus.underflow), 1);
        step(1'b0, 1'b1, 1'b1, 8'd0);
        chk("unf_clr2", int'(bus.underflow), 0);

        // Streaming with four in flight across the address wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(100 + i));
        saw_wrap = 1'b0;
        for (int i = 0; i < 36; i++) begin
            prev_waddr = bus.w_addr;
            step(1'b1, 1'b1, 1'b0, 8'(104 + i));
            if (prev_waddr == 5'd31 && bus.w_addr == 5'd0) saw_wrap = 1'b1;
            chk("stream_full", int'(bus.full), 0);
            chk("stream_cnt",  int'(bus.count), 4);
        end
        chk("saw_wrap", int'(saw_wrap), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("stream_empty", int'(bus.empty), 1);

        // Asynchronous reset with seven entries held.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'(200 + i));
        chk("pre_rst_cnt", int'(bus.count), 7);
        bus.wr = 1'b0;
        n_reset = 1'b0;
        #1;
        chk("arst_count", int'(bus.count), 0);
        chk("arst_empty", int'(bus.empty), 1);
        chk("arst_raddr", int'(bus.r_addr), 0);
        chk("arst_waddr", int'(bus.w_addr), 0);
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 8'd77);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        chk("post_rst_empty", int'(bus.empty), 1);

        chk("leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller placed directly upstream of reg_file.
- Turns push/pop requests into reg_file write enable, write address and read address.
- Paired with reg_file, forms a synchronous FIFO of depth 2^W. reg_file read port A is the FIFO head.
- Tracks occupancy and produces full/empty, programmable almost-full/almost-empty, and sticky error flags.

Parameters:
- W, 5: address width; FIFO depth = 2^W (matches reg_file W).
- AF_LEVEL, 28: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- n_reset  in  1  asynchronous active-low reset.
- wr  in  1  push request.
- rd  in  1  pop request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- wr_en  out  1  qualified write strobe to reg_file: wr & ~full, combinational.
- w_addr  out  W  reg_file write address = wr_ptr[W-1:0].
- r_addr  out  W  reg_file read address = rd_ptr[W-1:0], head entry.
- full  out  1  count == 2^W.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  W+1  current occupancy, 0..2^W.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (n_reset).
- n_reset low clears immediately, regardless of clk: wr_ptr=0, rd_ptr=0, overflow=0, underflow=0.
- Hence at reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0, w_addr=0, r_addr=0, wr_en=0.
- A reset mid-stream discards all occupancy. reg_file contents are not this block's concern.
- Pointers: wr_ptr and rd_ptr are W+1 bits and wrap naturally modulo 2^(W+1).
- count = wr_ptr - rd_ptr, computed in W+1 bits.
- full when the MSBs differ and the low W bits are equal; empty when wr_ptr == rd_ptr.
- All flags are combinational from the registered pointers, so they update in the cycle after the accepting edge.
- Push accepted when wr & ~full:
  - wr_en=1 in that cycle, so reg_file writes w_data at w_addr on the same edge.
  - wr_ptr increments on that edge.
- Pop accepted when rd & ~empty:
  - The head value is on reg_file r_data_A (r_addr_A tied to r_addr) before the edge. Consumer samples it in the same cycle; zero-latency show-ahead.
  - rd_ptr increments on the edge.
- Simultaneous wr & rd:
  - Neither full nor empty: both accepted; count unchanged; both pointers advance.
  - Full: pop accepted, push rejected (no pass-through); overflow sets.
  - Empty: push accepted, pop rejected (no bypass); underflow sets.
- Rejected requests change no pointer and leave wr_en=0.
- Error flags:
  - overflow sets on the edge where wr & full; underflow sets on the edge where rd & empty.
  - Both clear on an edge with clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: low address wraps from 2^W-1 to 0 with no gap; full/empty remain correct across wrap via the MSB.
- Parameter legality: 0 < AE_LEVEL < AF_LEVEL < 2^W. Checked by a simulation-only initial assertion.

Decomposition:
- Shared include fifo_defs: default W, default B, AF/AE default levels. Used by fifo_ctrl, reg_file instantiations and benches.
- fifo_ctrl has no sub-module.
- Integration wrapper fifo (separate file) instantiates fifo_ctrl + reg_file:
  - reg_file.wr_en ← fifo_ctrl.wr_en.
  - r_addr_A ← r_addr.
  - r_addr_B is exported for debug peek.
- Benches target the fifo wrapper with W=5, B=8.

Test Plan:
- Reset then idle: hold n_reset=0 20 ns, release → empty=1, full=0, count=0, almost_empty=1, r_addr=0, wr_en=0.
- Push 10, 15, 20 on consecutive cycles, then pop 3 → r_data_A reads 10, 15, 20 in order. count goes 1,2,3 then 2,1,0; empty=1 at end.
- Fill to 32 pushes (data = index) → almost_full rises when count reaches 28, full=1 at 32. A 33rd push gives wr_en=0, count stays 32, overflow=1. Pulse clr_err → overflow=0.
- Pop on empty after reset → count stays 0, underflow=1, r_addr unchanged at 0. Assert clr_err and rd together on empty → underflow stays 1 (set wins).
- Wrap test: push/pop 40 items streaming with 4 in flight → w_addr wraps 31→0. Data order is preserved; full never asserts; count stays 4 in steady state.
- Simultaneous wr & rd:
  - When full: count stays 32→31, full drops, head advances, overflow=1.
  - When empty: count 0→1, underflow=1.
  - Assert n_reset=0 mid-stream at count=7 → count=0 and empty=1 immediately, without waiting for a clock edge.
